aes_enc_core: RTL and testbench

- Iterative AES encryption core, parametrised for 128- or 256-bit keys.
- Performs one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) per clock and expands the key schedule on the fly.
- Uses valid/ready handshakes on input and output.
- Sits between the host data path and the output buffer; it is the full-round, multi-key-length successor to the team's SubBytes-stage engine.

---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_enc_core.sv | 128 ++++++++++++
 tb/tb_aes_enc_core.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) / byte-shuffling helpers for the iterative AES encryption core.
// Byte i of any 128-bit value sits at bits [8i+7:8i]; column c is bits [32c+31:32c].
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  function automatic logic [3:0] nr_of(input int key_bits);
    return (key_bits == 256) ? 4'd14 : 4'd10;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a3, a2, a1, a0} = a;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[32*c +: 32] = mix_column(s[32*c +: 32]);
    end
    return o;
  endfunction

  // Row r is rotated left by r: new[r][c] = old[r][(c+r)%4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  // Four-word key expansion step: word0 = base0 ^ t, word j = word j-1 ^ base j.
  function automatic logic [127:0] expand_key(input logic [127:0] base, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = base[31:0]   ^ t;
    w1 = base[63:32]  ^ w0;
    w2 = base[95:64]  ^ w1;
    w3 = base[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES encryptor: one full round per clock, key schedule expanded on the fly.
//   state | meaning
//   IDLE  | waiting for a plaintext/key handshake
//   ROUND | one cipher round per cycle, rnd = 1..NR
//   DONE  | ciphertext held on out_data until out_ready
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam logic [3:0] NR = nr_of(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_core: KEY_BITS must be 128 or 256");
  end

  aes_state_e          state_q, state_d;
  logic [127:0]        data_q, data_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [3:0]          rnd_q, rnd_d;

  logic [127:0]        sb, sr, round_data, round_key;
  logic [31:0]         ks_word_in, ks_word_sub;
  logic [KEY_BITS-1:0] key_next;

  for (genvar i = 0; i < 16; i++) begin : g_sbox_state
    aes_sbox u_sbox (
      .in_i  (data_q[8*i +: 8]),
      .out_o (sb[8*i +: 8])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox_key
    aes_sbox u_sbox (
      .in_i  (ks_word_in[8*i +: 8]),
      .out_o (ks_word_sub[8*i +: 8])
    );
  end

  if (KEY_BITS == 128) begin : g_ks128
    always_comb begin
      ks_word_in = rot_word(key_q[127:96]);
      round_key  = expand_key(key_q[127:0], ks_word_sub ^ {24'h0, rcon(rnd_q)});
      key_next   = round_key;
    end
  end else begin : g_ks256
    // key_q = {Khi, Klo}; Khi is this round's key, the next Khi is derived from Klo.
    logic [127:0] khi, knew;
    logic [3:0]   rcon_idx;
    always_comb begin
      khi        = key_q[255:128];
      rcon_idx   = (rnd_q + 4'd1) >> 1;
      ks_word_in = rnd_q[0] ? rot_word(khi[127:96]) : khi[127:96];
      knew       = expand_key(key_q[127:0],
                              ks_word_sub ^ (rnd_q[0] ? {24'h0, rcon(rcon_idx)} : 32'h0));
      round_key  = khi;
      key_next   = {knew, khi};
    end
  end

  always_comb begin
    sr         = shift_rows(sb);
    round_data = ((rnd_q == NR) ? sr : mix_columns(sr)) ^ round_key;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data ^ in_key[127:0];
          key_d   = in_key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_data;
        key_d  = key_next;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == NR) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// Directed bench for aes_enc_core: 128- and 256-bit instances, known-answer vectors via a scoreboard.
module tb_aes_enc_core;

  localparam logic [127:0] V1_D = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [255:0] V1_K = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] V1_E = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [255:0] K256 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] E256 = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] Z_E  = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic clk, rst_n;
  logic iv128, ir128, ov128, or128, busy128;
  logic [127:0] id128, ik128, od128;
  logic iv256, ir256, ov256, or256, busy256;
  logic [127:0] id256, od256;
  logic [255:0] ik256;

  logic [127:0] q128[$];
  logic [127:0] q256[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int base_cyc = 0;

  aes_enc_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv128), .in_ready(ir128), .in_data(id128),
    .in_key(ik128), .out_valid(ov128), .out_ready(or128), .out_data(od128), .busy(busy128)
  );

  aes_enc_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv256), .in_ready(ir256), .in_data(id256),
    .in_key(ik256), .out_valid(ov256), .out_ready(or256), .out_data(od256), .busy(busy256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input bit w, input logic v, input logic [127:0] d, input logic [255:0] k);
    if (w) begin
      iv256 = v; id256 = d; ik256 = k;
    end else begin
      iv128 = v; id128 = d; ik128 = k[127:0];
    end
  endtask

  task automatic set_or(input bit w, input logic v);
    if (w) or256 = v;
    else   or128 = v;
  endtask

  task automatic check_reset(input bit w, input string tag);
    check({tag, "_in_ready"},  w ? ir256   : ir128,   1'b1);
    check({tag, "_out_valid"}, w ? ov256   : ov128,   1'b0);
    check({tag, "_out_data"},  w ? od256   : od128,   128'h0);
    check({tag, "_busy"},      w ? busy256 : busy128, 1'b0);
  endtask

  // Offer a block, wait (bounded) for in_ready, push the expected ciphertext on the accept edge.
  task automatic accept(input bit w, input logic [127:0] d, input logic [255:0] k,
                        input logic [127:0] e);
    int n = 0;
    set_in(w, 1'b1, d, k);
    while (!(w ? ir256 : ir128) && n < 64) begin
      tick();
      n++;
    end
    check("accept_ready", w ? ir256 : ir128, 1'b1);
    tick();
    acc_cyc = cyc;
    set_in(w, 1'b0, '0, '0);
    if (w) q256.push_back(e);
    else   q128.push_back(e);
  endtask

  task automatic wait_out(input bit w, input int nr, input string tag);
    int n = 0;
    logic [127:0] e;
    while (!(w ? ov256 : ov128) && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(nr));
    e = 'x;
    if (w && q256.size() > 0) e = q256.pop_front();
    else if (!w && q128.size() > 0) e = q128.pop_front();
    check({tag, "_data"}, w ? od256 : od128, e);
  endtask

  task automatic handshake(input bit w, input string tag);
    set_or(w, 1'b1);
    tick();
    set_or(w, 1'b0);
    check({tag, "_valid_drop"}, w ? ov256 : ov128, 1'b0);
    check({tag, "_ready_back"}, w ? ir256 : ir128, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    or128 = 1'b0;
    or256 = 1'b0;
    repeat (3) tick();
    check_reset(1'b0, "rst128");
    check_reset(1'b1, "rst256");
    rst_n = 1'b1;
    tick();

    // Known answer, 128-bit key
    accept(1'b0, V1_D, V1_K, V1_E);
    check("v1_busy", busy128, 1'b1);
    wait_out(1'b0, 10, "v1");
    handshake(1'b0, "v1");

    // Known answer, 256-bit key
    accept(1'b1, V1_D, K256, E256);
    wait_out(1'b1, 14, "v256");
    handshake(1'b1, "v256");

    // All-zero key and plaintext
    accept(1'b0, '0, '0, Z_E);
    wait_out(1'b0, 10, "zero");
    handshake(1'b0, "zero");

    // in_valid pulsed while busy, then out_ready held low for five cycles
    accept(1'b0, V1_D, V1_K, V1_E);
    base_cyc = acc_cyc;
    tick();
    set_in(1'b0, 1'b1, '0, '0);
    repeat (3) begin
      check("ignore_in_ready", ir128, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, '0, '0);
    wait_out(1'b0, 10, "hold");
    for (int i = 0; i < 5; i++) begin
      check("hold_data", od128, V1_E);
      check("hold_in_ready", ir128, 1'b0);
      check("hold_valid", ov128, 1'b1);
      tick();
    end
    or128 = 1'b1;
    accept(1'b0, '0, '0, Z_E);
    or128 = 1'b0;
    // valid visible 6 cycles, handshake on the 6th, re-accept on the following edge
    check("hold_reaccept_edge", 128'(acc_cyc - base_cyc), 128'd17);
    wait_out(1'b0, 10, "after_hold");
    handshake(1'b0, "after_hold");

    // Back-to-back blocks with out_ready held high from the start
    or128 = 1'b1;
    accept(1'b0, V1_D, V1_K, V1_E);
    base_cyc = acc_cyc;
    wait_out(1'b0, 10, "tp1");
    accept(1'b0, '0, '0, Z_E);
    check("tp_accept_gap", 128'(acc_cyc - base_cyc), 128'd12);
    wait_out(1'b0, 10, "tp2");
    tick();
    check("tp2_valid_drop", ov128, 1'b0);
    or128 = 1'b0;

    // Reset asserted at rnd=5, then resend vector 1
    accept(1'b0, V1_D, V1_K, V1_E);
    repeat (4) tick();
    check("midrst_busy", busy128, 1'b1);
    rst_n = 1'b0;
    #1;
    q128.delete();
    check_reset(1'b0, "midrst");
    tick();
    check_reset(1'b0, "midrst_hold");
    rst_n = 1'b1;
    tick();
    accept(1'b0, V1_D, V1_K, V1_E);
    wait_out(1'b0, 10, "post_rst");
    handshake(1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
